// File: rtl/dp_sched_pkg.sv
// Shared definitions for the DP bank scheduler: bank-state encoding, default widths
// and the round-robin index wrap helper.
package dp_sched_pkg;

    localparam int CALC_WIDTH_DEF = 16;
    localparam int N_BANK_DEF     = 2;
    localparam int BANK_W_DEF     = $clog2(N_BANK_DEF);

    typedef enum logic [1:0] {
        BANK_FREE   = 2'd0,
        BANK_FILL   = 2'd1,
        BANK_QUEUED = 2'd2,
        BANK_TRACE  = 2'd3
    } bank_state_t;

    typedef logic [CALC_WIDTH_DEF-1:0] score_t;
    typedef logic [BANK_W_DEF-1:0]     bank_idx_t;

    // Wrap a bank index that may exceed the bank count by at most one lap.
    function automatic int bank_wrap(input int idx, input int n_bank);
        if (idx >= n_bank) begin
            return idx - n_bank;
        end else begin
            return idx;
        end
    endfunction

endpackage

// File: rtl/dp_bank_fifo.sv
// In-order queue of completed banks {bank, score}; head is the oldest entry.
// Push when full and pop when empty are dropped.
module dp_bank_fifo
    import dp_sched_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o = (cnt_q == CNT_W'(0));
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        if (do_push_s) begin
            wr_ptr_d = PTR_W'(bank_wrap(int'(wr_ptr_q) + 1, DEPTH));
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = PTR_W'(bank_wrap(int'(rd_ptr_q) + 1, DEPTH));
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/dp_bank_scheduler.sv
// Rotates systolic direction-memory writes over N_BANK banks and hands completed banks
// to traceback in order. Optional feature: SCORE_GATE_EN (drop low-score alignments).
module dp_bank_scheduler
    import dp_sched_pkg::*;
#(
    parameter int  N_BANK     = 2,
    parameter int  CALC_WIDTH = CALC_WIDTH_DEF,
    parameter int  CNT_W      = 16,
    localparam int BANK_W     = $clog2(N_BANK)
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  new_seq,
    input  logic [CALC_WIDTH-1:0] seq_max,
    input  logic [CALC_WIDTH-1:0] score_thr,
    output logic [BANK_W-1:0]     wr_bank,
    output logic                  stall,
    output logic                  tb_valid,
    output logic [BANK_W-1:0]     tb_bank,
    output logic [CALC_WIDTH-1:0] tb_score,
    input  logic                  tb_ready,
    input  logic                  tb_done,
    output logic                  proto_err,
    output logic [CNT_W-1:0]      skip_cnt
);

    localparam int ENTRY_W = BANK_W + CALC_WIDTH;

    bank_state_t           bank_st_q [N_BANK];
    bank_state_t           bank_st_d [N_BANK];
    logic [BANK_W-1:0]     wr_bank_q, wr_bank_d;
    logic                  stall_q, stall_d;
    logic                  proto_err_q, proto_err_d;
    logic [CNT_W-1:0]      skip_cnt_q, skip_cnt_d;

    logic                  trace_busy_s;
    logic [BANK_W-1:0]     trace_idx_s;
    logic                  gate_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ENTRY_W-1:0]    fifo_head_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic [BANK_W-1:0]     head_bank_s;
    logic                  alloc_found_s;
    logic [BANK_W-1:0]     alloc_idx_s;

`ifdef SCORE_GATE_EN
    assign gate_s = (seq_max < score_thr);
`else
    logic unused_thr_s;
    assign unused_thr_s = ^score_thr;
    assign gate_s       = 1'b0;
`endif

    dp_bank_fifo #(
        .DEPTH (N_BANK),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_i (reset_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   ({wr_bank_q, seq_max}),
        .head_o  (fifo_head_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s)
    );

    assign head_bank_s = fifo_head_s[ENTRY_W-1 -: BANK_W];
    assign tb_bank     = head_bank_s;
    assign tb_score    = fifo_head_s[CALC_WIDTH-1:0];
    assign tb_valid    = !fifo_empty_s && !trace_busy_s;
    assign wr_bank     = wr_bank_q;
    assign stall       = stall_q;
    assign proto_err   = proto_err_q;
    assign skip_cnt    = skip_cnt_q;

    // Locate the bank currently in traceback (at most one).
    always_comb begin
        trace_busy_s = 1'b0;
        trace_idx_s  = '0;
        for (int i = 0; i < N_BANK; i++) begin
            if (!trace_busy_s && (bank_st_q[i] == BANK_TRACE)) begin
                trace_busy_s = 1'b1;
                trace_idx_s  = BANK_W'(i);
            end else begin
                trace_busy_s = trace_busy_s;
            end
        end
    end

    // Bank state transitions in order: free, pop, retire, allocate.
    always_comb begin
        for (int i = 0; i < N_BANK; i++) begin
            bank_st_d[i] = bank_st_q[i];
        end
        wr_bank_d     = wr_bank_q;
        stall_d       = stall_q;
        proto_err_d   = proto_err_q;
        skip_cnt_d    = skip_cnt_q;
        push_s        = 1'b0;
        pop_s         = 1'b0;
        alloc_found_s = 1'b0;
        alloc_idx_s   = wr_bank_q;

        if (tb_done) begin
            if (trace_busy_s) begin
                bank_st_d[trace_idx_s] = BANK_FREE;
            end else begin
                proto_err_d = 1'b1;
            end
        end else begin
            proto_err_d = proto_err_q;
        end

        if (tb_valid && tb_ready) begin
            pop_s                  = 1'b1;
            bank_st_d[head_bank_s] = BANK_TRACE;
        end else begin
            pop_s = 1'b0;
        end

        if (new_seq && stall_q) begin
            proto_err_d = 1'b1;
        end else if (new_seq) begin
            if (gate_s) begin
                bank_st_d[wr_bank_q] = BANK_FREE;
                if (skip_cnt_q != {CNT_W{1'b1}}) begin
                    skip_cnt_d = skip_cnt_q + CNT_W'(1);
                end else begin
                    skip_cnt_d = skip_cnt_q;
                end
            end else begin
                bank_st_d[wr_bank_q] = BANK_QUEUED;
                push_s               = !fifo_full_s;
            end
        end else begin
            push_s = 1'b0;
        end

        // The writing bank itself is searched last so a gated bank can be refilled at once.
        if ((new_seq && !stall_q) || stall_q) begin
            for (int k = 1; k <= N_BANK; k++) begin
                if (!alloc_found_s && (bank_st_d[bank_wrap(int'(wr_bank_q) + k, N_BANK)] == BANK_FREE)) begin
                    alloc_found_s = 1'b1;
                    alloc_idx_s   = BANK_W'(bank_wrap(int'(wr_bank_q) + k, N_BANK));
                end else begin
                    alloc_found_s = alloc_found_s;
                end
            end
            if (alloc_found_s) begin
                bank_st_d[alloc_idx_s] = BANK_FILL;
                wr_bank_d              = alloc_idx_s;
                stall_d                = 1'b0;
            end else begin
                stall_d = 1'b1;
            end
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            for (int i = 0; i < N_BANK; i++) begin
                bank_st_q[i] <= (i == 0) ? BANK_FILL : BANK_FREE;
            end
            wr_bank_q   <= '0;
            stall_q     <= 1'b0;
            proto_err_q <= 1'b0;
            skip_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < N_BANK; i++) begin
                bank_st_q[i] <= bank_st_d[i];
            end
            wr_bank_q   <= wr_bank_d;
            stall_q     <= stall_d;
            proto_err_q <= proto_err_d;
            skip_cnt_q  <= skip_cnt_d;
        end
    end

endmodule
